// File: rtl/uart2_rx_fifo.sv
// Receive-side byte FIFO sitting directly behind the UART receiver.
// Bytes are captured on the receiver's one-cycle done strobe and held in a
// circular buffer. They are presented show-ahead on a valid/ready port.
// Fill level, an almost-full flag and a sticky overrun flag are also provided.
module uart2_rx_fifo #(
  parameter int DATA_W   = 8,
  parameter int DEPTH    = 16,
  parameter int AF_LEVEL = 12
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [DATA_W-1:0]             rx_byte_in,
  input  logic                          rx_byte_valid,
  output logic [DATA_W-1:0]             rd_data,
  output logic                          rd_valid,
  input  logic                          rd_ready,
  output logic [$clog2(DEPTH):0]        count,
  output logic                          almost_full,
  output logic                          overflow,
  input  logic                          overflow_clear,
  input  logic                          flush
);

  localparam int ADDR_W = $clog2(DEPTH);

  // Count-width copies of the size parameters so comparisons stay width-matched.
  localparam logic [ADDR_W:0] DEPTH_C = DEPTH[ADDR_W:0];
  localparam logic [ADDR_W:0] AF_C    = AF_LEVEL[ADDR_W:0];

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_overflow;

  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_overrun;
  logic w_wr_en;

  // Handshake decode. A full FIFO still accepts a byte when a pop frees a slot
  // in the same cycle. Without that pop, the byte is dropped.
  always_comb begin
    w_full    = (r_count == DEPTH_C);
    w_pop     = (r_count != '0) & rd_ready;
    w_push    = rx_byte_valid & (~w_full | w_pop);
    w_overrun = rx_byte_valid & w_full & ~w_pop;
    w_wr_en   = w_push & ~flush & ~reset;
  end

  // Storage array. It is deliberately not reset; entries are only observed
  // once written.
  always_ff @(posedge clock) begin
    if (w_wr_en) begin
      r_mem[r_wr_ptr] <= rx_byte_in;
    end
  end

  // Pointers, fill level and the sticky overrun flag.
  // Flush wins over push and pop, and leaves the overrun flag alone.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      if (w_push & ~w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop & ~w_push) begin
        r_count <= r_count - 1'b1;
      end
      // A new overrun takes precedence over a clear in the same cycle.
      if (w_overrun) begin
        r_overflow <= 1'b1;
      end else if (overflow_clear) begin
        r_overflow <= 1'b0;
      end
    end
  end

  // Show-ahead read port; the status flags are derived from the registered count.
  always_comb begin
    rd_data     = r_mem[r_rd_ptr];
    rd_valid    = (r_count != '0);
    count       = r_count;
    almost_full = (r_count >= AF_C);
    overflow    = r_overflow;
  end

endmodule

// File: tb/tb_uart2_rx_fifo.sv
// Testbench for uart2_rx_fifo.
// A queue-based reference model is compared against the DUT on every falling
// edge. Directed sequences add hand-computed literal checks on top of that.
module tb_uart2_rx_fifo;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] rx_byte_in;
  logic       rx_byte_valid;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [4:0] count;
  logic       almost_full;
  logic       overflow;
  logic       overflow_clear;
  logic       flush;

  uart2_rx_fifo #(.DATA_W(8), .DEPTH(16), .AF_LEVEL(12)) dut (
    .clock(clock), .reset(reset),
    .rx_byte_in(rx_byte_in), .rx_byte_valid(rx_byte_valid),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .count(count), .almost_full(almost_full),
    .overflow(overflow), .overflow_clear(overflow_clear), .flush(flush)
  );

  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;
  int max_cnt = 0;

  // Reference model state.
  logic [7:0] q[$];
  logic [7:0] rlog[$];
  bit         m_ovf = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: the FIFO as a bounded queue, updated from the inputs on
  // each rising edge.
  always @(posedge clock) begin
    bit pop_m, push_m, full_m;
    if (reset) begin
      q.delete();
      m_ovf = 1'b0;
    end else if (flush) begin
      q.delete();
    end else begin
      full_m = (q.size() == 16);
      pop_m  = (q.size() != 0) && rd_ready;
      push_m = rx_byte_valid && (!full_m || pop_m);
      if (pop_m) rlog.push_back(q.pop_front());
      if (push_m) q.push_back(rx_byte_in);
      if (rx_byte_valid && full_m && !pop_m) m_ovf = 1'b1;
      else if (overflow_clear) m_ovf = 1'b0;
    end
  end

  // Every-cycle comparison of the DUT outputs against the model.
  always @(negedge clock) begin
    if (chk_en) begin
      chk("rd_valid", rd_valid, (q.size() != 0));
      chk("count", count, q.size());
      chk("almost_full", almost_full, (q.size() >= 12));
      chk("overflow", overflow, m_ovf);
      if (q.size() != 0) chk("rd_data", rd_data, q[0]);
      if (int'(count) > max_cnt) max_cnt = int'(count);
    end
  end

  // One clock cycle with the given inputs. Inputs are applied just after a
  // falling edge, and the task returns on the next falling edge.
  task automatic cyc(input bit v, input logic [7:0] d, input bit rdy,
                     input bit fl = 1'b0, input bit clr = 1'b0, input bit rst = 1'b0);
    rx_byte_valid  = v;
    rx_byte_in     = d;
    rd_ready       = rdy;
    flush          = fl;
    overflow_clear = clr;
    reset          = rst;
    @(posedge clock);
    @(negedge clock);
    $display("[TB] t=%0t v=%0b d=%02h rdy=%0b fl=%0b clr=%0b rst=%0b -> cnt=%0d rv=%0b rd=%02h af=%0b ovf=%0b",
             $time, v, d, rdy, fl, clr, rst, count, rd_valid, rd_data, almost_full, overflow);
  endtask

  task automatic fill16();
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0);
  endtask

  task automatic drain();
    for (int i = 0; i < 20; i++) cyc(1'b0, 8'h00, 1'b1);
  endtask

  initial begin
    rx_byte_valid = 0; rx_byte_in = 0; rd_ready = 0;
    flush = 0; overflow_clear = 0; reset = 1;
    @(negedge clock);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1);
    chk_en = 1'b1;
    // Reset state
    chk("reset_count", count, 0);
    chk("reset_rd_valid", rd_valid, 0);
    chk("reset_af", almost_full, 0);
    chk("reset_ovf", overflow, 0);

    // T1: single push, then pop
    cyc(1'b1, 8'hA5, 1'b0);
    chk("t1_count", count, 1);
    chk("t1_rd_valid", rd_valid, 1);
    chk("t1_rd_data", rd_data, 8'hA5);
    cyc(1'b0, 8'h00, 1'b1);
    chk("t1_count_after_pop", count, 0);
    chk("t1_rd_valid_after_pop", rd_valid, 0);

    // T2: fill to 16, almost_full threshold, ordered drain
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      if (i == 10) chk("t2_af_at_11", almost_full, 0);
      if (i == 11) chk("t2_af_at_12", almost_full, 1);
    end
    chk("t2_count_full", count, 16);
    rlog.delete();
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      if (i == 3) chk("t2_af_at_12_drain", almost_full, 1);
      if (i == 4) chk("t2_af_at_11_drain", almost_full, 0);
    end
    chk("t2_read_count", rlog.size(), 16);
    for (int i = 0; i < 16 && i < rlog.size(); i++) chk("t2_order", rlog[i], i);

    // T3: overrun on a full FIFO, then clear
    fill16();
    cyc(1'b1, 8'hFF, 1'b0);
    chk("t3_ovf", overflow, 1);
    chk("t3_count", count, 16);
    rlog.delete();
    drain();
    chk("t3_read_count", rlog.size(), 16);
    for (int i = 0; i < 16 && i < rlog.size(); i++) chk("t3_order", rlog[i], i);
    chk("t3_ovf_sticky", overflow, 1);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    chk("t3_ovf_cleared", overflow, 0);

    // T4: push and pop on a full FIFO in the same cycle
    fill16();
    rlog.delete();
    cyc(1'b1, 8'h55, 1'b1);
    chk("t4_count", count, 16);
    chk("t4_ovf", overflow, 0);
    drain();
    chk("t4_read_count", rlog.size(), 17);
    if (rlog.size() == 17) begin
      chk("t4_first", rlog[0], 8'h00);
      chk("t4_last", rlog[16], 8'h55);
    end

    // T5: 40 pushes with random spacing and pops, fill level kept low across pointer wrap
    begin
      logic [7:0] sent[$];
      logic [7:0] b;
      rlog.delete();
      max_cnt = 0;
      for (int k = 0; k < 40; k++) begin
        b = 8'(k * 7 + 3);
        sent.push_back(b);
        cyc(1'b1, b, (q.size() >= 4) || ($urandom_range(0, 1) == 1));
        for (int g = $urandom_range(0, 2); g > 0; g--)
          cyc(1'b0, 8'h00, (q.size() >= 4) || ($urandom_range(0, 1) == 1));
      end
      drain();
      chk("t5_read_count", rlog.size(), 40);
      for (int i = 0; i < 40 && i < rlog.size(); i++) chk("t5_order", rlog[i], sent[i]);
      chk("t5_max_count_le5", (max_cnt <= 5), 1);
    end

    // T6: flush at count 7 with a simultaneous push, then reset mid-stream
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0);
    chk("t6_count7", count, 7);
    cyc(1'b1, 8'h33, 1'b0, 1'b1);
    chk("t6_flush_count", count, 0);
    chk("t6_flush_valid", rd_valid, 0);
    rlog.delete();
    cyc(1'b1, 8'h44, 1'b0);
    chk("t6_after_flush_data", rd_data, 8'h44);
    cyc(1'b0, 8'h00, 1'b1);
    chk("t6_no_33", (rlog.size() == 1) && (rlog[0] == 8'h44), 1);
    fill16();
    cyc(1'b1, 8'hEE, 1'b0);
    for (int i = 0; i < 7; i++) cyc(1'b0, 8'h00, 1'b1);
    chk("t6_count9", count, 9);
    chk("t6_ovf_before_reset", overflow, 1);
    cyc(1'b1, 8'h77, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_rst_count", count, 0);
    chk("t6_rst_valid", rd_valid, 0);
    chk("t6_rst_af", almost_full, 0);
    chk("t6_rst_ovf", overflow, 0);
    cyc(1'b0, 8'h00, 1'b0);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
